// File: rtl/game_pkg.sv
// game_pkg: state encoding, stage indices and default timeout shared by the frame sequencer
package game_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} seq_state_t;
    localparam int STG_INPUT = 0;
    localparam int STG_PLAYER = 1;
    localparam int STG_MOVE = 2;
    localparam int STG_COLLIDE = 3;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: timeout counter cleared on stage issue, counting while the stage is awaited
module stage_watchdog
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] count;
    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (run && !expired) count <= count + 1'b1;
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: runs the game-logic stages in order once per refresh tick, with timeouts and overrun tracking
module frame_sequencer
    import game_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FRAME_W = 16,
    parameter int OVR_W = 8
) (
    input  logic                  clk_50,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  refresh_tick,
    input  logic                  clr_status,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [2:0]            cur_stage,
    output logic                  busy,
    output logic                  frame_done,
    output logic [FRAME_W-1:0]    frame_count,
    output logic [OVR_W-1:0]      overrun_count,
    output logic [NUM_STAGES-1:0] timeout_mask
);
    seq_state_t state;
    logic pending;
    logic expired;
    logic [NUM_STAGES-1:0] cur_hot;
    logic done_cur;
    logic last;
    logic tick_ok;
    assign cur_hot = NUM_STAGES'(1) << cur_stage;
    assign done_cur = |(stage_done & cur_hot);
    assign last = cur_stage == 3'(NUM_STAGES - 1);
    assign tick_ok = refresh_tick && enable;
    assign busy = state != IDLE;
    stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .clear   (state == ISSUE),
        .run     (state == WAIT),
        .expired (expired)
    );
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur_stage <= '0;
            pending <= 1'b0;
            stage_start <= '0;
            frame_done <= 1'b0;
            frame_count <= '0;
            overrun_count <= '0;
            timeout_mask <= '0;
        end else begin
            stage_start <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (tick_ok || pending) begin
                    state <= ISSUE;
                    cur_stage <= 3'(STG_INPUT);
                    pending <= 1'b0;
                    stage_start <= NUM_STAGES'(1) << STG_INPUT;
                end
                ISSUE: state <= WAIT;
                WAIT: if (done_cur || expired) begin
                    // a done arriving in the expiry cycle counts as a normal completion
                    if (!done_cur) timeout_mask <= timeout_mask | cur_hot;
                    if (last) begin
                        state <= FINISH;
                        frame_done <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end else begin
                        state <= ISSUE;
                        cur_stage <= cur_stage + 3'd1;
                        stage_start <= cur_hot << 1;
                    end
                end
                FINISH: begin
                    state <= pending ? ISSUE : IDLE;
                    cur_stage <= '0;
                    pending <= 1'b0;
                    stage_start <= NUM_STAGES'(pending);
                end
                default: state <= IDLE;
            endcase
            // one tick may queue behind the running frame; further ticks are counted as dropped
            if (tick_ok && busy) begin
                if (!pending) pending <= 1'b1;
                else if (!(&overrun_count)) overrun_count <= overrun_count + 1'b1;
            end
            if (clr_status) begin
                timeout_mask <= '0;
                overrun_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed scenario tests for frame_sequencer with an auto-responding stage model
module tb_frame_sequencer;
    logic clk_50 = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic refresh_tick = 1'b0;
    logic clr_status = 1'b0;
    logic [3:0] stage_done, stage_start, timeout_mask;
    logic [3:0] resp_done = '0;
    logic [3:0] extra_done = '0;
    logic [2:0] cur_stage;
    logic busy, frame_done;
    logic [15:0] frame_count;
    logic [1:0] overrun_count;
    int total = 0;
    int bad = 0;
    int dly [4];
    int cnt [4];

    always #10 clk_50 = ~clk_50;
    assign stage_done = resp_done | extra_done;

    frame_sequencer #(.NUM_STAGES(4), .TIMEOUT_CYCLES(8), .FRAME_W(16), .OVR_W(2)) dut (
        .clk_50        (clk_50),
        .rst_n         (rst_n),
        .enable        (enable),
        .refresh_tick  (refresh_tick),
        .clr_status    (clr_status),
        .stage_done    (stage_done),
        .stage_start   (stage_start),
        .cur_stage     (cur_stage),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .timeout_mask  (timeout_mask)
    );

    task automatic step;
        @(posedge clk_50);
        #1;
    endtask

    // stage model: answers done dly[i] cycles after seeing its start pulse; dly 0 never answers
    initial begin
        for (int i = 0; i < 4; i++) begin
            dly[i] = 3;
            cnt[i] = 0;
        end
        forever begin
            @(posedge clk_50);
            #1;
            for (int i = 0; i < 4; i++) begin
                resp_done[i] = 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) resp_done[i] = 1'b1;
                end
                if (stage_start[i] && dly[i] != 0) cnt[i] = dly[i];
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) step;
        total++;
        if ({stage_start, cur_stage, busy, frame_done, frame_count, overrun_count, timeout_mask} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got start=%b stage=%0d busy=%b fd=%b fc=%0d ovr=%0d tmask=%b want all zero",
                     stage_start, cur_stage, busy, frame_done, frame_count, overrun_count, timeout_mask);
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_nominal;
        logic [3:0] exp_start;
        enable = 1'b1;
        for (int n = 0; n <= 18; n++) begin
            refresh_tick = (n == 0);
            if (n >= 1) begin
                exp_start = n == 1 ? 4'b0001 : n == 5 ? 4'b0010 : n == 9 ? 4'b0100 : n == 13 ? 4'b1000 : 4'b0000;
                total++;
                if (stage_start !== exp_start) begin
                    bad++;
                    $display("FAIL nominal_start cyc=%0d got=%b want=%b", n, stage_start, exp_start);
                end
                total++;
                if (frame_done !== (n == 17)) begin
                    bad++;
                    $display("FAIL nominal_frame_done cyc=%0d got=%b want=%b", n, frame_done, n == 17);
                end
            end
            if (n == 9) begin
                total++;
                if (cur_stage !== 3'd2) begin
                    bad++;
                    $display("FAIL nominal_cur_stage got=%0d want=2", cur_stage);
                end
            end
            step;
        end
        total++;
        if (frame_count !== 16'd1 || busy !== 1'b0 || cur_stage !== 3'd0) begin
            bad++;
            $display("FAIL nominal_end got fc=%0d busy=%b stage=%0d want fc=1 busy=0 stage=0", frame_count, busy, cur_stage);
        end
    endtask

    task automatic test_overrun;
        for (int n = 0; n <= 36; n++) begin
            refresh_tick = (n == 0 || n == 3 || n == 6 || n == 9);
            if (n == 10) begin
                total++;
                if (overrun_count !== 2'd2) begin
                    bad++;
                    $display("FAIL overrun_count got=%0d want=2", overrun_count);
                end
            end
            if (n == 18) begin
                total++;
                if (stage_start !== 4'b0001) begin
                    bad++;
                    $display("FAIL overrun_restart got=%b want=0001", stage_start);
                end
            end
            if (n >= 1) begin
                total++;
                if (frame_done !== (n == 17 || n == 34)) begin
                    bad++;
                    $display("FAIL overrun_frame_done cyc=%0d got=%b want=%b", n, frame_done, n == 17 || n == 34);
                end
            end
            step;
        end
        total++;
        if (frame_count !== 16'd3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun_end got fc=%0d busy=%b want fc=3 busy=0", frame_count, busy);
        end
    endtask

    task automatic test_collision;
        dly[1] = 8;
        for (int n = 0; n <= 24; n++) begin
            refresh_tick = (n == 0);
            extra_done = (n == 8) ? 4'b1000 : 4'b0000;
            if (n == 14 || n == 18) begin
                total++;
                if (stage_start !== (n == 14 ? 4'b0100 : 4'b1000)) begin
                    bad++;
                    $display("FAIL collision_start cyc=%0d got=%b want=%b", n, stage_start, n == 14 ? 4'b0100 : 4'b1000);
                end
            end
            if (n >= 1) begin
                total++;
                if (frame_done !== (n == 22)) begin
                    bad++;
                    $display("FAIL collision_frame_done cyc=%0d got=%b want=%b", n, frame_done, n == 22);
                end
            end
            step;
        end
        total++;
        if (timeout_mask !== 4'b0000 || frame_count !== 16'd4) begin
            bad++;
            $display("FAIL collision_end got tmask=%b fc=%0d want tmask=0000 fc=4", timeout_mask, frame_count);
        end
        dly[1] = 3;
    endtask

    task automatic test_timeout;
        dly[2] = 0;
        for (int n = 0; n <= 24; n++) begin
            refresh_tick = (n == 0);
            if (n == 17 || n == 18) begin
                total++;
                if (stage_start !== (n == 18 ? 4'b1000 : 4'b0000) || timeout_mask !== (n == 18 ? 4'b0100 : 4'b0000)) begin
                    bad++;
                    $display("FAIL timeout_advance cyc=%0d got start=%b tmask=%b want start=%b tmask=%b", n, stage_start,
                             timeout_mask, n == 18 ? 4'b1000 : 4'b0000, n == 18 ? 4'b0100 : 4'b0000);
                end
            end
            if (n >= 1) begin
                total++;
                if (frame_done !== (n == 22)) begin
                    bad++;
                    $display("FAIL timeout_frame_done cyc=%0d got=%b want=%b", n, frame_done, n == 22);
                end
            end
            step;
        end
        total++;
        if (timeout_mask !== 4'b0100 || frame_count !== 16'd5 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_end got tmask=%b fc=%0d busy=%b want tmask=0100 fc=5 busy=0", timeout_mask, frame_count, busy);
        end
        dly[2] = 3;
    endtask

    task automatic test_reset_mid_clr;
        for (int n = 0; n <= 10; n++) begin
            refresh_tick = (n == 0);
            step;
        end
        total++;
        if (busy !== 1'b1 || cur_stage !== 3'd2) begin
            bad++;
            $display("FAIL reset_mid_pre got busy=%b stage=%0d want busy=1 stage=2", busy, cur_stage);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({stage_start, cur_stage, busy, frame_done, frame_count, overrun_count, timeout_mask} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async got start=%b stage=%0d busy=%b fc=%0d ovr=%0d tmask=%b want all zero",
                     stage_start, cur_stage, busy, frame_count, overrun_count, timeout_mask);
        end
        for (int k = 0; k < 4; k++) begin
            step;
            total++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_hold k=%0d got fd=%b busy=%b want 0 0", k, frame_done, busy);
            end
        end
        rst_n = 1'b1;
        step;
        dly[2] = 0;
        for (int n = 0; n <= 46; n++) begin
            refresh_tick = (n == 0 || n == 3 || n == 6);
            clr_status = (n == 46);
            if (n == 45) begin
                total++;
                if (timeout_mask !== 4'b0100 || overrun_count !== 2'd1 || frame_count !== 16'd2) begin
                    bad++;
                    $display("FAIL pre_clear got tmask=%b ovr=%0d fc=%0d want tmask=0100 ovr=1 fc=2", timeout_mask, overrun_count, frame_count);
                end
            end
            if (n >= 1) begin
                total++;
                if (frame_done !== (n == 22 || n == 44)) begin
                    bad++;
                    $display("FAIL post_reset_frame_done cyc=%0d got=%b want=%b", n, frame_done, n == 22 || n == 44);
                end
            end
            step;
        end
        clr_status = 1'b0;
        total++;
        if (timeout_mask !== 4'b0000 || overrun_count !== 2'd0 || frame_count !== 16'd2) begin
            bad++;
            $display("FAIL clr_status got tmask=%b ovr=%0d fc=%0d want tmask=0000 ovr=0 fc=2", timeout_mask, overrun_count, frame_count);
        end
        dly[2] = 3;
    endtask

    task automatic test_enable_sat;
        enable = 1'b0;
        for (int n = 0; n <= 7; n++) begin
            refresh_tick = (n % 2 == 0);
            if (n >= 1) begin
                total++;
                if (stage_start !== 4'b0000 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL enable_gate cyc=%0d got start=%b busy=%b want 0000 0", n, stage_start, busy);
                end
            end
            step;
        end
        for (int n = 0; n <= 36; n++) begin
            refresh_tick = (n % 2 == 0 && n <= 12);
            enable = (n <= 12);
            if (n == 7 || n == 14) begin
                total++;
                if (overrun_count !== (n == 7 ? 2'd2 : 2'd3)) begin
                    bad++;
                    $display("FAIL saturate cyc=%0d got=%0d want=%0d", n, overrun_count, n == 7 ? 2 : 3);
                end
            end
            if (n == 18) begin
                total++;
                if (stage_start !== 4'b0001) begin
                    bad++;
                    $display("FAIL pending_after_disable got=%b want=0001", stage_start);
                end
            end
            if (n >= 1) begin
                total++;
                if (frame_done !== (n == 17 || n == 34)) begin
                    bad++;
                    $display("FAIL sat_frame_done cyc=%0d got=%b want=%b", n, frame_done, n == 17 || n == 34);
                end
            end
            step;
        end
        total++;
        if (frame_count !== 16'd4 || busy !== 1'b0 || overrun_count !== 2'd3) begin
            bad++;
            $display("FAIL sat_end got fc=%0d busy=%b ovr=%0d want fc=4 busy=0 ovr=3", frame_count, busy, overrun_count);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_overrun;
        test_collision;
        test_timeout;
        test_reset_mid_clr;
        test_enable_sat;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
